wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 8 +
 rtl/regfile_2r1w.sv | 32 +++
 rtl/wb_regfile.sv | 65 ++++++
 tb/tb_wb_regfile.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage and its register file.
// Widths, register count and the JAL link offset live here so every file agrees.
package wb_regfile_pkg;
    localparam int XLEN            = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int NUM_REGS        = 32;
    localparam int JAL_LINK_OFFSET = 4;
endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational read ports, one clocked write port.
// x0 is hardwired to zero; all other entries clear asynchronously on rst.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr1,
    input  logic [REG_ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0]     o_rdata1,
    output logic [DATA_W-1:0]     o_rdata2
);
    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result, commits it to the register file, and
// bypasses it to same-cycle decode reads; also counts committed writes.
module wb_regfile #(
    parameter int XLEN = wb_regfile_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       Read_data_in,
    input  logic [XLEN-1:0]       ALU_result_in,
    input  logic [XLEN-1:0]       PC_number_in,
    input  logic [4:0]            Rd_in,
    input  logic                  MemtoReg_in,
    input  logic                  RegWrite_in,
    input  logic                  is_jal_in,
    input  logic [4:0]            Rs1_addr,
    input  logic [4:0]            Rs2_addr,
    output logic [XLEN-1:0]       Rs1_data,
    output logic [XLEN-1:0]       Rs2_data,
    output logic [XLEN-1:0]       wb_data_out,
    output logic                  wb_we_out,
    output logic [31:0]           retired_count
);
    import wb_regfile_pkg::*;

    logic [XLEN-1:0] w_wb_data;
    logic            w_we;
    logic [XLEN-1:0] w_rf_rdata1;
    logic [XLEN-1:0] w_rf_rdata2;
    logic [31:0]     r_retired_count;

    // Link address wraps naturally at 2^XLEN.
    assign w_wb_data = is_jal_in   ? (PC_number_in + XLEN'(JAL_LINK_OFFSET)) :
                       MemtoReg_in ? Read_data_in : ALU_result_in;
    assign w_we      = RegWrite_in && (Rd_in != '0) && !rst;

    regfile_2r1w #(
        .DATA_W   (XLEN)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (Rd_in),
        .i_wdata  (w_wb_data),
        .i_raddr1 (Rs1_addr),
        .i_raddr2 (Rs2_addr),
        .o_rdata1 (w_rf_rdata1),
        .o_rdata2 (w_rf_rdata2)
    );

    // w_we is low in reset and for x0, so the bypass never leaks a value there.
    assign Rs1_data = (w_we && (Rs1_addr == Rd_in)) ? w_wb_data : w_rf_rdata1;
    assign Rs2_data = (w_we && (Rs2_addr == Rd_in)) ? w_wb_data : w_rf_rdata2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired_count <= '0;
        end else if (w_we) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    assign wb_data_out   = w_wb_data;
    assign wb_we_out     = w_we;
    assign retired_count = r_retired_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, randomized traffic against a
// reference model, plus reset, first-write and counter-wrap sequences.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Read_data_in, ALU_result_in, PC_number_in;
    logic [4:0]  Rd_in, Rs1_addr, Rs2_addr;
    logic        MemtoReg_in, RegWrite_in, is_jal_in;
    logic [31:0] Rs1_data, Rs2_data, wb_data_out, retired_count;
    logic        wb_we_out;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    typedef struct {
        logic        rw, m2r, jal;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] alu, rdat, pc;
        logic [31:0] e_wb;
        logic        e_we;
        logic [31:0] e_rs1, e_rs2, e_cnt;
    } vec_t;

    vec_t tbl [8];

    wb_regfile #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .Read_data_in  (Read_data_in),
        .ALU_result_in (ALU_result_in),
        .PC_number_in  (PC_number_in),
        .Rd_in         (Rd_in),
        .MemtoReg_in   (MemtoReg_in),
        .RegWrite_in   (RegWrite_in),
        .is_jal_in     (is_jal_in),
        .Rs1_addr      (Rs1_addr),
        .Rs2_addr      (Rs2_addr),
        .Rs1_data      (Rs1_data),
        .Rs2_data      (Rs2_data),
        .wb_data_out   (wb_data_out),
        .wb_we_out     (wb_we_out),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the architectural rules stated directly.
    function automatic logic [31:0] model_wb(input vec_t v);
        if (v.jal)      return v.pc + 32'd4;
        else if (v.m2r) return v.rdat;
        else            return v.alu;
    endfunction

    function automatic logic model_we(input vec_t v);
        return v.rw && (v.rd != 5'd0);
    endfunction

    function automatic logic [31:0] model_read(input vec_t v, input logic [4:0] a);
        if (model_we(v) && a == v.rd) return model_wb(v);
        if (a == 5'd0)                return 32'd0;
        return m_regs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
    endtask

    task automatic drive(input vec_t v);
        RegWrite_in   = v.rw;
        MemtoReg_in   = v.m2r;
        is_jal_in     = v.jal;
        Rd_in         = v.rd;
        Rs1_addr      = v.rs1;
        Rs2_addr      = v.rs2;
        ALU_result_in = v.alu;
        Read_data_in  = v.rdat;
        PC_number_in  = v.pc;
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic run_vec(input string tag, input vec_t v);
        drive(v);
        #1;
        check({tag, " wb_data"}, wb_data_out, v.e_wb);
        check({tag, " wb_we"},   {31'd0, wb_we_out}, {31'd0, v.e_we});
        check({tag, " rs1"},     Rs1_data, v.e_rs1);
        check({tag, " rs2"},     Rs2_data, v.e_rs2);
        @(posedge clk);
        if (model_we(v)) begin
            m_regs[v.rd] = model_wb(v);
            m_cnt        = m_cnt + 32'd1;
        end
        #1;
        check({tag, " count"}, retired_count, v.e_cnt);
        @(negedge clk);
    endtask

    task automatic fill_expect(inout vec_t v);
        v.e_wb  = model_wb(v);
        v.e_we  = model_we(v);
        v.e_rs1 = model_read(v, v.rs1);
        v.e_rs2 = model_read(v, v.rs2);
        v.e_cnt = m_cnt + (model_we(v) ? 32'd1 : 32'd0);
    endtask

    initial begin
        vec_t v;

        //          rw   m2r  jal  rd     rs1    rs2    alu            rdat           pc             e_wb           e_we e_rs1          e_rs2          e_cnt
        tbl[0] = '{1'b1,1'b0,1'b0,5'd5, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 1'b1,32'hDEADBEEF, 32'h0,        32'd1};
        tbl[1] = '{1'b0,1'b0,1'b0,5'd5, 5'd5, 5'd5, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0,32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
        tbl[2] = '{1'b1,1'b1,1'b0,5'd7, 5'd7, 5'd7, 32'h0000AAAA, 32'h12345678, 32'h0,        32'h12345678, 1'b1,32'h12345678, 32'h12345678, 32'd2};
        tbl[3] = '{1'b1,1'b1,1'b1,5'd1, 5'd1, 5'd7, 32'h0,        32'h0BADF00D, 32'h00000100, 32'h00000104, 1'b1,32'h00000104, 32'h12345678, 32'd3};
        tbl[4] = '{1'b1,1'b0,1'b1,5'd1, 5'd1, 5'd5, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h00000000, 1'b1,32'h00000000, 32'hDEADBEEF, 32'd4};
        tbl[5] = '{1'b0,1'b0,1'b1,5'd1, 5'd1, 5'd7, 32'h55,       32'h0,        32'h00000200, 32'h00000204, 1'b0,32'h00000000, 32'h12345678, 32'd4};
        tbl[6] = '{1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0,32'h00000000, 32'h00000000, 32'd4};
        tbl[7] = '{1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd5, 32'h0,        32'h0,        32'h0,        32'h00000000, 1'b0,32'h00000000, 32'hDEADBEEF, 32'd4};

        // Reset state, with a live write request that must not bypass or commit.
        rst = 1'b1;
        model_clear();
        v = tbl[0];
        v.rs2 = 5'd5;
        drive(v);
        #3;
        check("rst wb_we", {31'd0, wb_we_out}, 32'd0);
        check("rst count", retired_count, 32'd0);
        check("rst rs1",   Rs1_data, 32'd0);
        check("rst rs2",   Rs2_data, 32'd0);
        check("rst wb_data", wb_data_out, 32'hDEADBEEF);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i]);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            v.rw   = ($urandom_range(0, 9) < 7);
            v.m2r  = $urandom_range(0, 1);
            v.jal  = ($urandom_range(0, 5) == 0);
            v.rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v.rs1  = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
            v.rs2  = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
            v.alu  = $urandom;
            v.rdat = $urandom;
            v.pc   = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            fill_expect(v);
            run_vec($sformatf("rnd%0d", n), v);
        end

        // Asynchronous reset between edges kills the in-flight write.
        v = '{1'b1,1'b0,1'b0,5'd3,5'd3,5'd3,32'hCAFEF00D,32'h0,32'h0,32'h0,1'b0,32'h0,32'h0,32'h0};
        drive(v);
        #2 rst = 1'b1;
        #1;
        check("arst wb_we", {31'd0, wb_we_out}, 32'd0);
        check("arst count", retired_count, 32'd0);
        check("arst bypass rs1", Rs1_data, 32'd0);
        for (int a = 1; a < 32; a++) begin
            Rs1_addr = 5'(a);
            Rs2_addr = 5'(32 - a);
            #1;
            check($sformatf("arst rs1 x%0d", a), Rs1_data, 32'd0);
            check($sformatf("arst rs2 x%0d", 32 - a), Rs2_data, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();

        // First write lands on the first posedge after release.
        v = '{1'b1,1'b0,1'b0,5'd3,5'd3,5'd5,32'h13579BDF,32'h0,32'h0,32'h0,1'b0,32'h0,32'h0,32'h0};
        fill_expect(v);
        run_vec("first_wr", v);
        v = '{1'b0,1'b0,1'b0,5'd0,5'd3,5'd5,32'h0,32'h0,32'h0,32'h0,1'b0,32'h0,32'h0,32'h0};
        fill_expect(v);
        run_vec("post_wr", v);

        // Counter wrap: preload all-ones, then commit one write.
        drive(v);
        force dut.r_retired_count = 32'hFFFFFFFF;
        #1;
        release dut.r_retired_count;
        #1;
        check("wrap preload", retired_count, 32'hFFFFFFFF);
        m_cnt = 32'hFFFFFFFF;
        @(negedge clk);
        v = '{1'b1,1'b0,1'b0,5'd9,5'd9,5'd3,32'h00C0FFEE,32'h0,32'h0,32'h0,1'b0,32'h0,32'h0,32'h0};
        fill_expect(v);
        run_vec("wrap", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
